// File: rtl/regmem_sb.sv
// Register memory with write-back dest/data select, same-cycle bypass and a pending-write scoreboard.
// Optional build macro REGMEM_R0_ZERO_EN: register 0 is hard-wired to zero and never marked busy.
module regmem_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int LINK_REG = DEPTH - 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_sel1_i,
  input  logic [$clog2(DEPTH)-1:0]   rd_sel2_i,
  output logic [WIDTH-1:0]           rd_data1_o,
  output logic [WIDTH-1:0]           rd_data2_o,
  input  logic                       wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]   wr_sel_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       lbi_i,
  input  logic                       link_i,
  input  logic [WIDTH-1:0]           imm_i,
  input  logic [WIDTH-1:0]           pc_addr_i,
  input  logic                       issue_valid_i,
  input  logic [$clog2(DEPTH)-1:0]   issue_dst_i,
  output logic                       busy1_o,
  output logic                       busy2_o,
  output logic                       stall_o,
  output logic                       err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LinkSel = AW'(LINK_REG);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             err_q, err_d;

  logic [AW-1:0]    wrDest;
  logic [WIDTH-1:0] wrData;
  logic             wrCommit;
  logic             issueSet;
  logic             hit1, hit2;

  // Link has priority over lbi, which has priority over the plain write-back path.
  always_comb begin
    wrDest = wr_sel_i;
    wrData = wr_data_i;
    if (link_i) begin
      wrDest = LinkSel;
      wrData = pc_addr_i;
    end else if (lbi_i) begin
      wrDest = rd_sel1_i;
      wrData = imm_i;
    end
`ifdef REGMEM_R0_ZERO_EN
    wrCommit = wr_en_i && (wrDest != '0);
    issueSet = issue_valid_i && (issue_dst_i != '0);
`else
    wrCommit = wr_en_i;
    issueSet = issue_valid_i;
`endif
  end

  always_comb begin
    hit1       = wr_en_i && (wrDest == rd_sel1_i);
    hit2       = wr_en_i && (wrDest == rd_sel2_i);
    rd_data1_o = hit1 ? wrData : regs_q[rd_sel1_i];
    rd_data2_o = hit2 ? wrData : regs_q[rd_sel2_i];
`ifdef REGMEM_R0_ZERO_EN
    if (rd_sel1_i == '0) rd_data1_o = '0;
    if (rd_sel2_i == '0) rd_data2_o = '0;
`endif
    busy1_o = busy_q[rd_sel1_i] & ~hit1;
    busy2_o = busy_q[rd_sel2_i] & ~hit2;
    stall_o = busy1_o | busy2_o;
    err_o   = err_q;
  end

  // A commit clears its busy bit before a same-cycle issue sets it, so a new producer wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wrCommit) regs_d[wrDest] = wrData;
    if (wr_en_i) busy_d[wrDest] = 1'b0;
    if (issueSet) busy_d[issue_dst_i] = 1'b1;
    err_d = err_q | (wr_en_i & lbi_i & link_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

endmodule
